// File: rtl/lcd_hd44780_sequencer.sv
// HD44780 4-bit LCD sequencer: power-on init, then byte writes split into timed E-strobed nibbles.
// Optional input FIFO enabled by defining LCD_SEQ_FIFO_EN.
module lcd_hd44780_sequencer #(
    parameter int         POWERUP_CYCLES    = 375000,
    parameter int         INIT1_CYCLES      = 103000,
    parameter int         INIT2_CYCLES      = 2500,
    parameter int         CMD_CYCLES        = 1000,
    parameter int         LONG_CMD_CYCLES   = 50000,
    parameter int         SETUP_CYCLES      = 10,
    parameter int         PULSE_CYCLES      = 12,
    parameter int         NIBBLE_GAP_CYCLES = 25,
    parameter logic [7:0] FUNC_SET          = 8'h28,
    parameter logic [7:0] DISP_CTRL         = 8'h0C,
    parameter logic [7:0] ENTRY_MODE        = 8'h06
) (
    input  logic       clk_25mhz,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       init_done,
    output logic       busy,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = maxOf(maxOf(maxOf(POWERUP_CYCLES, INIT1_CYCLES), maxOf(INIT2_CYCLES, CMD_CYCLES)),
                                   maxOf(maxOf(LONG_CMD_CYCLES, SETUP_CYCLES), maxOf(PULSE_CYCLES, NIBBLE_GAP_CYCLES)));
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] L_PWR   = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] L_INIT1 = CW'(INIT1_CYCLES - 1);
    localparam logic [CW-1:0] L_INIT2 = CW'(INIT2_CYCLES - 1);
    localparam logic [CW-1:0] L_CMD   = CW'(CMD_CYCLES - 1);
    localparam logic [CW-1:0] L_LONG  = CW'(LONG_CMD_CYCLES - 1);
    localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] L_PULSE = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] L_GAP   = CW'(NIBBLE_GAP_CYCLES - 1);

    // Clear and home (commands 0x01..0x03) need the long execution wait.
    function automatic logic [CW-1:0] execLast(input logic rs, input logic [7:0] d);
        return (!rs && d[7:2] == 6'd0) ? L_LONG : L_CMD;
    endfunction

    typedef enum logic [2:0] {PWR_WAIT, NIB_SETUP, NIB_HIGH, NIB_LOW, IDLE, LOAD} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_step;
    logic [7:0]      r_byte;
    logic            r_rs;
    logic            r_second;
    logic [CW-1:0]   r_execLast;
    logic            r_initDone;
    logic            r_idleReady;
    logic            r_engBusy;
    logic [3:0]      r_lcdData;
    logic            r_lcdRs;
    logic            r_lcdE;

    logic [7:0]      w_itemData;
    logic            w_itemIsByte;
    logic [CW-1:0]   w_itemLast;
    logic [CW-1:0]   w_lowLast;
    logic            w_take;
    logic            w_takeRs;
    logic [7:0]      w_takeData;

    // Init items: the first four are lone nibbles carried in the high half.
    always_comb begin
        w_itemData   = 8'h00;
        w_itemIsByte = 1'b0;
        w_itemLast   = L_CMD;
        case (r_step)
            4'd0: begin w_itemData = 8'h30; w_itemLast = L_INIT1; end
            4'd1: begin w_itemData = 8'h30; w_itemLast = L_INIT2; end
            4'd2: begin w_itemData = 8'h30; w_itemLast = L_CMD;   end
            4'd3: begin w_itemData = 8'h20; w_itemLast = L_CMD;   end
            4'd4: begin w_itemData = FUNC_SET;   w_itemIsByte = 1'b1; w_itemLast = execLast(1'b0, FUNC_SET);   end
            4'd5: begin w_itemData = DISP_CTRL;  w_itemIsByte = 1'b1; w_itemLast = execLast(1'b0, DISP_CTRL);  end
            4'd6: begin w_itemData = 8'h01;      w_itemIsByte = 1'b1; w_itemLast = execLast(1'b0, 8'h01);      end
            4'd7: begin w_itemData = ENTRY_MODE; w_itemIsByte = 1'b1; w_itemLast = execLast(1'b0, ENTRY_MODE); end
            default: ;
        endcase
    end

    assign w_lowLast = r_second ? L_GAP : r_execLast;

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= PWR_WAIT;
            r_cnt       <= '0;
            r_step      <= '0;
            r_byte      <= '0;
            r_rs        <= 1'b0;
            r_second    <= 1'b0;
            r_execLast  <= '0;
            r_initDone  <= 1'b0;
            r_idleReady <= 1'b0;
            r_engBusy   <= 1'b1;
            r_lcdData   <= '0;
            r_lcdRs     <= 1'b0;
            r_lcdE      <= 1'b0;
        end else begin
            case (r_state)
                PWR_WAIT: begin
                    if (r_cnt == L_PWR) begin
                        r_cnt      <= '0;
                        r_state    <= NIB_SETUP;
                        r_step     <= r_step + 4'd1;
                        r_byte     <= w_itemData;
                        r_rs       <= 1'b0;
                        r_second   <= w_itemIsByte;
                        r_execLast <= w_itemLast;
                        r_lcdData  <= w_itemData[7:4];
                        r_lcdRs    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                NIB_SETUP: begin
                    if (r_cnt == L_SETUP) begin
                        r_cnt   <= '0;
                        r_lcdE  <= 1'b1;
                        r_state <= NIB_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                NIB_HIGH: begin
                    if (r_cnt == L_PULSE) begin
                        r_cnt   <= '0;
                        r_lcdE  <= 1'b0;
                        r_state <= NIB_LOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // E-low wait: nibble gap if the low half is pending, else the execution wait.
                NIB_LOW: begin
                    if (r_cnt == w_lowLast) begin
                        r_cnt <= '0;
                        if (r_second) begin
                            r_second  <= 1'b0;
                            r_lcdData <= r_byte[3:0];
                            r_state   <= NIB_SETUP;
                        end else if (!r_initDone && r_step != 4'd8) begin
                            r_state    <= NIB_SETUP;
                            r_step     <= r_step + 4'd1;
                            r_byte     <= w_itemData;
                            r_rs       <= 1'b0;
                            r_second   <= w_itemIsByte;
                            r_execLast <= w_itemLast;
                            r_lcdData  <= w_itemData[7:4];
                            r_lcdRs    <= 1'b0;
                        end else begin
                            r_state     <= IDLE;
                            r_initDone  <= 1'b1;
                            r_idleReady <= 1'b1;
                            r_engBusy   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_take) begin
                        r_byte      <= w_takeData;
                        r_rs        <= w_takeRs;
                        r_execLast  <= execLast(w_takeRs, w_takeData);
                        r_idleReady <= 1'b0;
                        r_engBusy   <= 1'b1;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    r_lcdData <= r_byte[7:4];
                    r_lcdRs   <= r_rs;
                    r_second  <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= NIB_SETUP;
                end
                default: r_state <= PWR_WAIT;
            endcase
        end
    end

`ifdef LCD_SEQ_FIFO_EN
    logic [8:0] r_fifo [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_count;
    logic       r_fifoReady;
    logic       r_fifoNz;
    logic       w_push;
    logic [2:0] w_countNext;

    // Pop only sees the registered count, so a push into an empty FIFO pops a cycle later.
    assign w_push      = in_valid & r_fifoReady;
    assign w_take      = r_idleReady & (r_count != 3'd0);
    assign w_takeRs    = r_fifo[r_rp][8];
    assign w_takeData  = r_fifo[r_rp][7:0];
    assign w_countNext = r_count + {2'b00, w_push} - {2'b00, w_take};

    always_ff @(posedge clk_25mhz) begin
        if (w_push) r_fifo[r_wp] <= {in_rs, in_data};
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_fifoReady <= 1'b0;
            r_fifoNz    <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 2'd1;
            if (w_take) r_rp <= r_rp + 2'd1;
            r_count     <= w_countNext;
            r_fifoReady <= (w_countNext != 3'd4);
            r_fifoNz    <= (w_countNext != 3'd0);
        end
    end

    assign in_ready = r_fifoReady;
    assign busy     = r_engBusy | r_fifoNz;
`else
    assign w_take     = r_idleReady & in_valid;
    assign w_takeRs   = in_rs;
    assign w_takeData = in_data;
    assign in_ready   = r_idleReady;
    assign busy       = r_engBusy;
`endif

    assign init_done = r_initDone;
    assign lcd_data  = r_lcdData;
    assign lcd_rs    = r_lcdRs;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = r_lcdE;

endmodule

// File: tb/tb_lcd_hd44780_sequencer.sv
// Bench for lcd_hd44780_sequencer with reduced timing; E pulses are logged and compared to a timing model.
module tb_lcd_hd44780_sequencer;

    localparam int PWR  = 100;
    localparam int I1   = 50;
    localparam int I2   = 20;
    localparam int CMD  = 10;
    localparam int LONG = 40;
    localparam int S    = 10;
    localparam int P    = 12;
    localparam int G    = 25;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_rs;
    logic [7:0] in_data;
    logic       in_ready;
    logic       init_done;
    logic       busy;
    logic [3:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    lcd_hd44780_sequencer #(
        .POWERUP_CYCLES(PWR), .INIT1_CYCLES(I1), .INIT2_CYCLES(I2),
        .CMD_CYCLES(CMD), .LONG_CMD_CYCLES(LONG)
    ) dut (
        .clk_25mhz(clk), .reset_n(reset_n), .in_valid(in_valid), .in_rs(in_rs),
        .in_data(in_data), .in_ready(in_ready), .init_done(init_done), .busy(busy),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    int         riseQ[$];
    int         fallQ[$];
    logic [3:0] dataQ[$];
    logic       rsQ[$];
    int         expRise[$];
    logic [3:0] expData[$];
    logic       expRs[$];

    int         stableErr = 0;
    logic       prevE = 1'b0;
    logic [3:0] curData = 4'h0;
    logic       curRs = 1'b0;

    logic [3:0] initNib [4]   = '{4'h3, 4'h3, 4'h3, 4'h2};
    int         initWait [4]  = '{I1, I2, CMD, CMD};
    logic [7:0] initBytes [4] = '{8'h28, 8'h0C, 8'h01, 8'h06};

    // Pulse logger: records each E pulse and flags any data/RS change while E is high.
    always @(negedge clk) begin
        if (lcd_e === 1'b1 && prevE !== 1'b1) begin
            riseQ.push_back(cyc);
            dataQ.push_back(lcd_data);
            rsQ.push_back(lcd_rs);
            curData = lcd_data;
            curRs   = lcd_rs;
        end else if (lcd_e === 1'b1 && (lcd_data !== curData || lcd_rs !== curRs)) begin
            stableErr++;
        end
        if (lcd_e !== 1'b1 && prevE === 1'b1) fallQ.push_back(cyc);
        prevE = lcd_e;
    end

    function automatic int execOf(input logic rs, input logic [7:0] d);
        return (!rs && d < 8'd4) ? LONG : CMD;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expectByte(input logic rs, input logic [7:0] d, input int rise);
        expData.push_back(d[7:4]); expRs.push_back(rs); expRise.push_back(rise);
        expData.push_back(d[3:0]); expRs.push_back(rs); expRise.push_back(rise + P + G + S);
    endtask

    task automatic expectInit(input int rel, output int doneCyc);
        int t;
        t = rel + PWR + S;
        for (int i = 0; i < 4; i++) begin
            expData.push_back(initNib[i]); expRs.push_back(1'b0); expRise.push_back(t);
            t = t + P + initWait[i] + S;
        end
        for (int i = 0; i < 4; i++) begin
            expectByte(1'b0, initBytes[i], t);
            t = t + 2 * P + G + S + execOf(1'b0, initBytes[i]) + S;
        end
        doneCyc = t - S;
    endtask

    task automatic clearQueues();
        riseQ.delete(); fallQ.delete(); dataQ.delete(); rsQ.delete();
        expRise.delete(); expData.delete(); expRs.delete();
    endtask

    task automatic comparePulses(input string tag);
        checkOutput({tag, " pulseCount"}, riseQ.size(), expRise.size());
        checkOutput({tag, " fallCount"}, fallQ.size(), riseQ.size());
        for (int i = 0; i < expRise.size() && i < riseQ.size(); i++) begin
            checkOutput($sformatf("%s nib%0d data", tag, i), dataQ[i], expData[i]);
            checkOutput($sformatf("%s nib%0d rs", tag, i), rsQ[i], expRs[i]);
            checkOutput($sformatf("%s nib%0d riseCycle", tag, i), riseQ[i], expRise[i]);
            if (i < fallQ.size())
                checkOutput($sformatf("%s nib%0d eWidth", tag, i), fallQ[i] - riseQ[i], P);
        end
        clearQueues();
    endtask

    // Presents a request, waits for the handshake, then leaves the bus with junk and valid low.
    task automatic applyStimulus(input logic rs, input logic [7:0] d, output int acc);
        int n;
        in_valid = 1'b1; in_rs = rs; in_data = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("acceptReady", in_ready, 1'b1);
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_rs    = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic waitReady(output int lows);
        lows = 0;
        while (in_ready !== 1'b1 && lows < 2000) begin
            lows++;
            @(negedge clk);
        end
    endtask

    task automatic waitInit(output int doneCyc, output int readyHigh);
        int n;
        n = 0; readyHigh = 0;
        while (init_done !== 1'b1 && n < 3000) begin
            if (in_ready === 1'b1) readyHigh++;
            @(negedge clk);
            n++;
        end
        checkOutput("initDoneReached", init_done, 1'b1);
        doneCyc = cyc;
    endtask

    task automatic sendByte(input logic rs, input logic [7:0] d, input string tag,
                            input logic holdValid, input logic holdRs, input logic [7:0] holdData,
                            output int acc);
        int lows;
        applyStimulus(rs, d, acc);
        if (holdValid) begin
            in_valid = 1'b1; in_rs = holdRs; in_data = holdData;
        end
        expectByte(rs, d, acc + 2 + S);
        checkOutput({tag, " busyActive"}, busy, 1'b1);
        checkOutput({tag, " readyDropped"}, in_ready, 1'b0);
        waitReady(lows);
        checkOutput({tag, " readyLowCycles"}, lows, 1 + 2 * (S + P) + G + execOf(rs, d));
        checkOutput({tag, " busyIdle"}, busy, 1'b0);
        comparePulses(tag);
    endtask

    initial begin
        int doneExp, doneCyc, readyHigh, rel, acc, acc2, n;
        logic       rs;
        logic [7:0] d;

        reset_n = 1'b0; in_valid = 1'b0; in_rs = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst in_ready", in_ready, 1'b0);
        checkOutput("rst init_done", init_done, 1'b0);
        checkOutput("rst busy", busy, 1'b1);
        checkOutput("rst lcd_e", lcd_e, 1'b0);
        checkOutput("rst lcd_data", lcd_data, 4'h0);
        checkOutput("rst lcd_rs", lcd_rs, 1'b0);
        checkOutput("rst lcd_rw", lcd_rw, 1'b0);

        // Request held through the whole init sequence.
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h55;
        reset_n = 1'b1;
        rel = cyc;
        expectInit(rel, doneExp);
        @(negedge clk);
        checkOutput("init busy", busy, 1'b1);
        waitInit(doneCyc, readyHigh);
        checkOutput("init doneCycle", doneCyc, doneExp);
        checkOutput("init readyHeldOff", readyHigh, 0);
        checkOutput("init readyAtDone", in_ready, 1'b1);
        checkOutput("init busyAtDone", busy, 1'b0);
        comparePulses("init");

        sendByte(1'b1, 8'h55, "held55", 1'b0, 1'b0, 8'h00, acc);
        checkOutput("held55 acceptCycle", acc, doneExp);

        sendByte(1'b1, 8'h41, "data41", 1'b1, 1'b1, 8'h55, acc);
        sendByte(1'b1, 8'h55, "held55b", 1'b0, 1'b0, 8'h00, acc2);
        checkOutput("bytePeriod", acc2 - acc, 1 + 2 * (S + P) + G + CMD + 1);

        sendByte(1'b0, 8'h01, "clear01", 1'b0, 1'b0, 8'h00, acc);
        sendByte(1'b0, 8'h04, "cmd04", 1'b0, 1'b0, 8'h00, acc);

        for (int k = 0; k < 16; k++) begin
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 7));
            else d = 8'($urandom_range(0, 255));
            sendByte(rs, d, $sformatf("rnd%0d", k), 1'b0, 1'b0, 8'h00, acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of an E pulse.
        applyStimulus(1'b0, 8'h28, acc);
        n = 0;
        while (lcd_e !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midPulse eHigh", lcd_e, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midReset lcd_e", lcd_e, 1'b0);
        checkOutput("midReset busy", busy, 1'b1);
        checkOutput("midReset in_ready", in_ready, 1'b0);
        checkOutput("midReset init_done", init_done, 1'b0);
        @(negedge clk);
        #1 clearQueues();
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        expectInit(rel, doneExp);
        repeat (PWR) @(negedge clk);
        checkOutput("reinit initDoneLow", init_done, 1'b0);
        checkOutput("reinit busy", busy, 1'b1);
        waitInit(doneCyc, readyHigh);
        checkOutput("reinit doneCycle", doneCyc, doneExp);
        checkOutput("reinit readyHeldOff", readyHigh, 0);
        comparePulses("reinit");

        sendByte(1'b0, 8'h02, "home02", 1'b0, 1'b0, 8'h00, acc);
        checkOutput("eStable", stableErr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

endmodule
